// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, then releases system reset.
// Build option PLL_LOCK_AUTO_RETRY_EN: a lock timeout re-pulses the PLL instead of parking in S_FAIL.
`timescale 1ns/1ps
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [3:0] timeout_count
);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

`ifdef PLL_LOCK_AUTO_RETRY_EN
    localparam state_t TIMEOUT_STATE = S_PLLRST;
`else
    localparam state_t TIMEOUT_STATE = S_FAIL;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] tmo;
    logic [CNT_W-1:0] tmo_nxt;
    logic             locked_m;
    logic             locked_s;
    logic             timeout_hit;
    logic             relock_hit;
    logic             pll_rst_nxt;
    logic             sys_rst_nxt;
    logic             ready_nxt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    // Outputs are registered from the next-state decode so they change on the transition edge itself.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state   <= S_PLLRST;
            cnt     <= '0;
            tmo     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tmo     <= tmo_nxt;
            pll_rst <= pll_rst_nxt;
            sys_rst <= sys_rst_nxt;
            ready   <= ready_nxt;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            relock_count  <= 8'd0;
            timeout_count <= 4'd0;
        end else begin
            if (relock_hit && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
            if (timeout_hit && (timeout_count != 4'hF)) begin
                timeout_count <= timeout_count + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tmo_nxt     = tmo;
        timeout_hit = 1'b0;
        relock_hit  = 1'b0;
        case (state)
            S_PLLRST: begin
                if (cnt == PLL_RST_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                    tmo_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_WAIT: begin
                tmo_nxt = tmo + CNT_ONE;
                if (locked_s) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = '0;
                end
            end
            S_STABLE: begin
                // The timeout window spans the whole lock attempt, so a dropout does not restart it.
                tmo_nxt = tmo + CNT_ONE;
                if (!locked_s) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_nxt  = S_WAIT;
                    tmo_nxt    = '0;
                    relock_hit = 1'b1;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_PLLRST;
                cnt_nxt   = '0;
            end
        endcase

        // Timeout overrides any other transition, including release to S_RUN on the same edge.
        if (((state == S_WAIT) || (state == S_STABLE)) && (tmo == TIMEOUT_LAST)) begin
            timeout_hit = 1'b1;
            state_nxt   = TIMEOUT_STATE;
            cnt_nxt     = '0;
        end
    end

    always_comb begin
        pll_rst_nxt = 1'b0;
        sys_rst_nxt = 1'b1;
        ready_nxt   = 1'b0;
        case (state_nxt)
            S_PLLRST: begin
                pll_rst_nxt = 1'b1;
            end
            S_RUN: begin
                sys_rst_nxt = 1'b0;
                ready_nxt   = 1'b1;
            end
            default: begin
                pll_rst_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: table-driven bring-up/relock/glitch vectors plus timeout,
// collision and async-reset sequences, all checked through an expected-value queue.
`timescale 1ns/100ps
module tb_pll_lock_sequencer;

    localparam int PLL_RST_CYCLES      = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 64;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_count;
    logic [3:0] timeout_count;

    typedef struct {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic [7:0] relock;
        logic [3:0] tmo_cnt;
        string      name;
    } exp_t;

    typedef struct {
        logic rst;
        logic locked;
        int   cycles;
        exp_t exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[15];
    int   n_compared    = 0;
    int   n_mismatched  = 0;
    int   pll_rst_rises = 0;
    int   rises_snap    = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .CNT_W              (20)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .relock_count (relock_count),
        .timeout_count(timeout_count)
    );

    always #5 refclk = ~refclk;

    always @(posedge pll_rst) pll_rst_rises++;

    function automatic exp_t mk(input int p, input int s, input int r, input int rc, input int tc,
                                input string nm);
        exp_t e;
        e.pll_rst = (p != 0);
        e.sys_rst = (s != 0);
        e.ready   = (r != 0);
        e.relock  = 8'(rc);
        e.tmo_cnt = 4'(tc);
        e.name    = nm;
        return e;
    endfunction

    function automatic vec_t mkv(input int r, input int l, input int n, input exp_t e);
        vec_t v;
        v.rst    = (r != 0);
        v.locked = (l != 0);
        v.cycles = n;
        v.exp    = e;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic l, input int n, input exp_t e);
        sb_q.push_back(e);
        rst    = r;
        locked = l;
        repeat (n) @(negedge refclk);
    endtask

    task automatic checkOutput();
        exp_t e;
        n_compared++;
        if (sb_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_underflow: got no expected entry, required one");
        end else begin
            e = sb_q.pop_front();
            if ({pll_rst, sys_rst, ready, relock_count, timeout_count} !==
                {e.pll_rst, e.sys_rst, e.ready, e.relock, e.tmo_cnt}) begin
                n_mismatched++;
                $display("[TB] FAIL %s: got pll_rst=%b sys_rst=%b ready=%b relock=%0d timeouts=%0d, required pll_rst=%b sys_rst=%b ready=%b relock=%0d timeouts=%0d",
                         e.name, pll_rst, sys_rst, ready, relock_count, timeout_count,
                         e.pll_rst, e.sys_rst, e.ready, e.relock, e.tmo_cnt);
            end
        end
    endtask

    task automatic runStep(input int r, input int l, input int n, input exp_t e);
        applyStimulus(r != 0, l != 0, n, e);
        checkOutput();
    endtask

    initial begin
        // Expectations for locked rising 10 cycles after pll_rst falls, two RUN dropouts and a stable-window glitch.
        vecs[0]  = mkv(1, 0, 2,  mk(1, 1, 0, 0, 0, "reset_state"));
        vecs[1]  = mkv(0, 0, 3,  mk(1, 1, 0, 0, 0, "pllrst_held"));
        vecs[2]  = mkv(0, 0, 1,  mk(0, 1, 0, 0, 0, "pllrst_drop"));
        vecs[3]  = mkv(0, 0, 10, mk(0, 1, 0, 0, 0, "wait_unlocked"));
        vecs[4]  = mkv(0, 1, 10, mk(0, 1, 0, 0, 0, "stable_before_release"));
        vecs[5]  = mkv(0, 1, 1,  mk(0, 0, 1, 0, 0, "ready_rise"));
        vecs[6]  = mkv(0, 0, 2,  mk(0, 0, 1, 0, 0, "run_loss_sync_delay"));
        vecs[7]  = mkv(0, 0, 1,  mk(0, 1, 0, 1, 0, "run_loss_sys_rst"));
        vecs[8]  = mkv(0, 1, 10, mk(0, 1, 0, 1, 0, "relock_window"));
        vecs[9]  = mkv(0, 1, 1,  mk(0, 0, 1, 1, 0, "relock_ready"));
        vecs[10] = mkv(0, 0, 3,  mk(0, 1, 0, 2, 0, "second_loss"));
        vecs[11] = mkv(0, 1, 5,  mk(0, 1, 0, 2, 0, "glitch_pre"));
        vecs[12] = mkv(0, 0, 1,  mk(0, 1, 0, 2, 0, "glitch_low"));
        vecs[13] = mkv(0, 1, 10, mk(0, 1, 0, 2, 0, "glitch_recount"));
        vecs[14] = mkv(0, 1, 1,  mk(0, 0, 1, 2, 0, "glitch_ready"));

        rst    = 1'b1;
        locked = 1'b0;
        @(negedge refclk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].locked, vecs[i].cycles, vecs[i].exp);
            checkOutput();
            if (i == 2) rises_snap = pll_rst_rises;
        end

        $display("[TB] relock saturation sequence");
        for (int i = 0; i < 300; i++) begin
            int rc;
            rc = (3 + i > 255) ? 255 : 3 + i;
            runStep(0, 0, 3,  mk(0, 1, 0, rc, 0, "sat_loss"));
            runStep(0, 1, 11, mk(0, 0, 1, rc, 0, "sat_relock"));
        end

        n_compared++;
        if (pll_rst_rises != rises_snap) begin
            n_mismatched++;
            $display("[TB] FAIL no_pll_rst_pulse_on_loss: got %0d pll_rst rises, required %0d",
                     pll_rst_rises, rises_snap);
        end

        $display("[TB] async reset mid-run");
        #2;
        applyStimulus(1'b1, 1'b1, 0, mk(1, 1, 0, 0, 0, "async_reset_immediate"));
        #0.5;
        checkOutput();
        #0.5;
        rst = 1'b0;
        runStep(0, 1, 1, mk(1, 1, 0, 0, 0, "post_async_release"));

        $display("[TB] lock timeout sequence");
        runStep(1, 0, 2, mk(1, 1, 0, 0, 0, "timeout_reset"));
`ifdef PLL_LOCK_AUTO_RETRY_EN
        for (int k = 0; k < 17; k++) begin
            int tc;
            int tn;
            tc = (k > 15) ? 15 : k;
            tn = (k + 1 > 15) ? 15 : k + 1;
            runStep(0, 0, 3,  mk(1, 1, 0, 0, tc, "retry_pllrst_high"));
            runStep(0, 0, 1,  mk(0, 1, 0, 0, tc, "retry_pllrst_low"));
            runStep(0, 0, 63, mk(0, 1, 0, 0, tc, "retry_wait"));
            runStep(0, 0, 1,  mk(1, 1, 0, 0, tn, "retry_timeout"));
        end
`else
        runStep(0, 0, 67, mk(0, 1, 0, 0, 0, "wait_before_timeout"));
        runStep(0, 0, 1,  mk(0, 1, 0, 0, 1, "timeout_to_fail"));
        runStep(0, 1, 30, mk(0, 1, 0, 0, 1, "fail_ignores_locked"));
`endif

        $display("[TB] timeout versus release collision");
        runStep(1, 0, 2,  mk(1, 1, 0, 0, 0, "collision_reset"));
        runStep(0, 0, 57, mk(0, 1, 0, 0, 0, "collision_wait"));
        runStep(0, 1, 10, mk(0, 1, 0, 0, 0, "collision_stable"));
`ifdef PLL_LOCK_AUTO_RETRY_EN
        runStep(0, 1, 1,  mk(1, 1, 0, 0, 1, "collision_timeout_wins"));
        runStep(0, 1, 1,  mk(1, 1, 0, 0, 1, "collision_after"));
`else
        runStep(0, 1, 1,  mk(0, 1, 0, 0, 1, "collision_timeout_wins"));
        runStep(0, 1, 1,  mk(0, 1, 0, 0, 1, "collision_after"));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
